fetch_stage: RTL and testbench

- Instruction fetch stage; sits directly upstream of decode and supplies its instruction input.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small show-ahead FIFO and presents them to decode with a valid/ready handshake.
- Supports a PC redirect from later stages; the redirect flushes buffered and in-flight fetches.

---
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: in-order instruction fetch with a show-ahead buffer and redirect flush; FETCH_PERF_EN adds stall/fetch counters
module fetch_stage #(
  parameter int WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [WORD_SIZE-1:0] imem_resp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          stall_count,
  output logic [31:0]          fetch_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  logic [WORD_SIZE-1:0] fetch_pc, resp_pc, target;
  logic [WORD_SIZE-1:0] fifo_data [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_pc [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, drop_count;
  logic accept, push, pop;
  // Credit rule: in-flight plus buffered never exceeds the buffer, so pushes never overflow
  always_comb begin
    target = redirect_pc & ~WORD_SIZE'(3);
    instr_valid = count != '0;
    imem_req_valid = !reset && !redirect_valid && (outstanding + count < DEPTH);
    imem_req_addr = fetch_pc;
    accept = imem_req_valid && imem_req_ready;
    push = !reset && imem_resp_valid && !redirect_valid && drop_count == '0;
    pop = instr_valid && instr_ready && !redirect_valid;
    instruction = instr_valid ? fifo_data[rd_ptr] : '0;
    instr_pc = instr_valid ? fifo_pc[rd_ptr] : '0;
  end
  // PCs and credit tracking; a redirect marks every response still in flight as stale
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_count <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        fetch_pc <= target;
        resp_pc <= target;
        drop_count <= outstanding - CW'(imem_resp_valid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + WORD_SIZE'(4);
        if (push) resp_pc <= resp_pc + WORD_SIZE'(4);
        if (imem_resp_valid && drop_count != '0) drop_count <= drop_count - CW'(1);
      end
    end
  // Buffer pointers and occupancy; redirect flushes and wins over a same-cycle pop
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // Buffer storage; outputs are gated by instr_valid so no reset is needed here
  always_ff @(posedge clock)
    if (push) begin
      fifo_data[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr] <= resp_pc;
    end
`ifdef FETCH_PERF_EN
  // Saturating performance counters that survive redirects
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      stall_count <= '0;
      fetch_count <= '0;
    end else begin
      if (instr_valid && !instr_ready && stall_count != '1) stall_count <= stall_count + 32'd1;
      if (push && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage ordering, backpressure, redirect and reset
module tb_fetch_stage;
  localparam logic [31:0] KEY = 32'hDEAD_0000;
  logic clock = 0, reset = 1;
  logic redirect_valid = 0, imem_req_ready = 1, imem_resp_valid = 0, instr_ready = 0;
  logic [31:0] redirect_pc = '0, imem_resp_data = '0;
  logic imem_req_valid, instr_valid;
  logic [31:0] imem_req_addr, instruction, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_count, fetch_count;
`endif
  logic [31:0] pend [$];
  logic mem_on = 1;
  int n_acc = 0, checks = 0, errors = 0, bub = 0;

  fetch_stage dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    , .stall_count(stall_count), .fetch_count(fetch_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: record an accepted request, then answer the oldest pending one a cycle later
  task automatic step();
    logic acc;
    logic [31:0] a;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    @(posedge clock);
    if (acc) begin
      pend.push_back(a);
      n_acc++;
    end
    @(negedge clock);
    imem_resp_valid = 0;
    if (mem_on && pend.size() > 0) begin
      imem_resp_valid = 1;
      imem_resp_data = pend.pop_front() ^ KEY;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    redirect_valid = 0;
    imem_resp_valid = 0;
    instr_ready = 0;
    mem_on = 1;
    pend.delete();
    repeat (2) @(negedge clock);
    reset = 0;
    n_acc = 0;
    #1;
  endtask

  // Drain n instructions, expecting consecutive PCs from first with matching data
  task automatic consume(input string tag, input logic [31:0] first, input int n, output int bubbles);
    logic [31:0] exp;
    int got;
    exp = first;
    got = 0;
    bubbles = 0;
    instr_ready = 1;
    for (int i = 0; i < 40 && got < n; i++) begin
      if (instr_valid) begin
        check({tag, "_pc"}, instr_pc, exp);
        check({tag, "_data"}, instruction, exp ^ KEY);
        exp += 4;
        got++;
      end else if (got > 0) bubbles++;
      step();
    end
    check({tag, "_count"}, got, n);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instruction", instruction, 0);
    check("rst_instr_pc", instr_pc, 0);
    reset = 0;
    instr_ready = 1;
    #1;
    check("t1_addr0", imem_req_addr, 32'h0);
    step();
    check("t1_addr1", imem_req_addr, 32'h4);
    check("t1_empty_before_resp", instr_valid, 0);
    step();
    check("t1_addr2", imem_req_addr, 32'h8);
    check("t1_latency_valid", instr_valid, 1);
    consume("t1", 32'h0, 6, bub);
    check("t1_bubbles", bub, 0);

    do_reset();
    repeat (8) step();
    check("t2_req_count", n_acc, 4);
    check("t2_req_valid_off", imem_req_valid, 0);
    check("t2_head_pc", instr_pc, 32'h0);
    consume("t2", 32'h0, 6, bub);

    do_reset();
    instr_ready = 1;
    mem_on = 0;
    repeat (3) step();
    check("t3_inflight", n_acc, 3);
    redirect_valid = 1;
    redirect_pc = 32'h103;
    #1;
    check("t3_no_req_on_redirect", imem_req_valid, 0);
    step();
    redirect_valid = 0;
    mem_on = 1;
    #1;
    check("t3_addr", imem_req_addr, 32'h100);
    check("t3_req_valid", imem_req_valid, 1);
    consume("t3", 32'h100, 4, bub);

    do_reset();
    repeat (3) step();
    check("t4_two_buffered", instr_valid, 1);
    check("t4_resp_pending", imem_resp_valid, 1);
    redirect_valid = 1;
    redirect_pc = 32'h200;
    instr_ready = 1;
    step();
    check("t4_flushed", instr_valid, 0);
    redirect_valid = 0;
    consume("t4", 32'h200, 4, bub);

    do_reset();
    repeat (3) step();
    check("t5_buffered", instr_valid, 1);
    reset = 1;
    #1;
    check("t5_async_valid", instr_valid, 0);
    check("t5_async_req", imem_req_valid, 0);
    check("t5_async_instr", instruction, 0);
    pend.delete();
    repeat (2) step();
    reset = 0;
    #1;
    check("t5_addr", imem_req_addr, 32'h0);
    consume("t5", 32'h0, 4, bub);

`ifdef FETCH_PERF_EN
    do_reset();
    repeat (2) step();
    check("t6_head", instr_valid, 1);
    repeat (10) step();
    check("t6_stall", stall_count, 10);
    check("t6_fetch", fetch_count, 4);
    redirect_valid = 1;
    redirect_pc = 32'h300;
    step();
    redirect_valid = 0;
    check("t6_stall_kept", stall_count, 11);
    check("t6_fetch_kept", fetch_count, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
